wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the RV32I core: it merges single-cycle ALU results and buffered load results from the LSU onto the register file's single write port. It also keeps a per-register scoreboard of outstanding loads, so issue logic can stall on read-after-load hazards. It sits between the execute/LSU stages and the register file write port (address, enable, data).

## Interface
- DEPTH, 4: load-result FIFO entries (power of two, ≥2)
- CNTW, 3: width of each per-register pending counter
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  load result valid
- lsu_ready  out  1  FIFO can accept; equals !full
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load result
- iss_valid  in  1  load issued this cycle
- iss_rd  in  5  destination of the issued load
- rs1, rs2  in  5  source registers of the instruction in decode
- hz_rs1, hz_rs2  out  1  source register has an outstanding load
- wb_we  out  1  register file write enable
- wb_rd  out  5  register file write address
- wb_data  out  32  register file write data
- waw_err  out  1  sticky: ALU wrote a register with an outstanding load
- busy  out  1  FIFO non-empty or wb_we high

## Operation
- Reset (async, rst_n low):
  - wb_we = 0, wb_rd = 0, wb_data = 0.
  - FIFO empty; pointers and count = 0.
  - All pending counters = 0; waw_err = 0.
  - lsu_ready = 1; busy = 0.
- FIFO accepts a load result when lsu_valid && lsu_ready.
  - When lsu_rd == 0, the result is accepted but not stored. It also counts as a retire for x0, which is a no-op.
- Arbitration, evaluated each cycle:
  - When alu_valid && alu_rd != 0, the ALU wins the port.
  - Otherwise, when the FIFO is non-empty, the head is popped and written.
  - Otherwise the cycle is an idle write (wb_we = 0).
  - An ALU result with alu_rd == 0 is discarded and does not block the FIFO.
- wb_we, wb_rd and wb_data are registered from the arbitration choice.
  - wb_rd and wb_data hold their last values when wb_we = 0.
- Push and pop in the same cycle are allowed: count is unchanged and data order is preserved.
- Push is impossible when full. Pop from empty never occurs.
- Scoreboard: one CNTW-bit counter per register; counter 0 is always 0.
  - Increment on iss_valid && iss_rd != 0.
  - Decrement when a FIFO entry for that rd is popped into wb.
  - Increment and decrement of the same register in the same cycle leave the counter unchanged.
  - Counters saturate at 2^CNTW−1 and never wrap below 0.
- hz_rs1 = (pending[rs1] != 0); hz_rs2 likewise. Both are combinational from current state; x0 never hazards.
- waw_err is set when the arbiter selects an ALU write whose alu_rd has a pending count != 0. It is cleared only by reset.
- busy = (count != 0) || wb_we.

## Timing
- ALU path latency is 1 cycle: alu_valid sampled at edge k gives wb_we = 1 after edge k. The register file then commits at edge k+1.
- Load path latency is at least 2 cycles: push at edge k, the head is selectable in cycle k+1, and wb_we = 1 after edge k+1. Each consecutive ALU win adds 1 cycle.
- lsu_ready is combinational from count. It drops in the cycle after the push that fills the FIFO, unless a pop happens in the same cycle.
- The pending decrement takes effect at the same edge that raises wb_we for that load. The hazard is therefore cleared one cycle before the register file holds the data, so decode must use forwarding from wb_* for that cycle.
- Throughput is one register file write per cycle. Sustained back-to-back ALU writes starve the FIFO; this is intended, and LSU backpressure covers it.

## Test plan
- Reset: hold rst_n low mid-traffic, with FIFO at 3 entries and pending[5] = 2 → outputs zero immediately, lsu_ready = 1, hz_* = 0, busy = 0.
- ALU only: alu_valid with rd = 3, data 0xDEADBEEF, at edge k → wb_we = 1, wb_rd = 3, wb_data = 0xDEADBEEF after edge k. An ALU write with rd = 0 produces no wb_we.
- Load path: issue rd = 7, then push lsu rd = 7, data 0x12345678 → hz_rs1 = 1 while rs1 = 7. wb_we rises 2 cycles after the push and hz clears at the same edge.
- Contention and full: 4 load pushes (rd = 1..4) while the ALU writes every cycle → lsu_ready = 0 after the 4th push. When the ALU stops, rd 1..4 are written in order on 4 consecutive cycles.
- Simultaneous events: issue rd = 9 in the same cycle a pending rd = 9 load pops → pending[9] is unchanged. Push and pop at count = 2 → count stays 2.
- WAW check: pending[6] = 1 and the ALU writes rd = 6 → waw_err = 1 and remains sticky until reset.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's execute/LSU/issue/decode/regfile signals.
// slave is the arbiter's view; master is the view of whatever drives it.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hz_rs1;
  logic        hz_rs2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        waw_err;
  logic        busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output lsu_ready, hz_rs1, hz_rs2,
    output wb_we, wb_rd, wb_data, waw_err, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  lsu_ready, hz_rs1, hz_rs2,
    input  wb_we, wb_rd, wb_data, waw_err, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results onto the
// single register file write port, and tracks outstanding loads per register
// so decode can stall on read-after-load hazards.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [4:0]      fifo_rd   [DEPTH];
  logic [31:0]     fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CNTW-1:0] pending [32];

  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        alu_win;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [31:0] sb_inc;
  logic [31:0] sb_dec;

  logic        wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        waw_q;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign accept    = bus.lsu_valid && !full;
  // Loads to x0 are acknowledged but never stored, so the FIFO head is never x0.
  assign push      = accept && (bus.lsu_rd != 5'd0);
  // An ALU result for x0 is dropped and lets the FIFO drain in the same cycle.
  assign alu_win   = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign pop       = !alu_win && !empty;
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Per-register increment/decrement requests for the scoreboard.
  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) sb_inc[bus.iss_rd] = 1'b1;
    if (pop) sb_dec[head_rd] = 1'b1;
  end

  // Load-result storage; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lsu_rd;
      fifo_data[wr_ptr] <= bus.lsu_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating pending-load counters; x0 is pinned to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (i == 0) begin
          pending[i] <= '0;
        end else if (sb_inc[i] && !sb_dec[i]) begin
          if (pending[i] != CNT_MAX) pending[i] <= pending[i] + 1'b1;
        end else if (sb_dec[i] && !sb_inc[i]) begin
          if (pending[i] != '0) pending[i] <= pending[i] - 1'b1;
        end
      end
    end
  end

  // Registered write port; address and data hold while no write is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q <= alu_win || pop;
      if (alu_win) begin
        wb_rd_q   <= bus.alu_rd;
        wb_data_q <= bus.alu_data;
      end else if (pop) begin
        wb_rd_q   <= head_rd;
        wb_data_q <= head_data;
      end
    end
  end

  // Sticky flag for an ALU write overtaking an outstanding load to the same rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waw_q <= 1'b0;
    end else if (alu_win && (pending[bus.alu_rd] != '0)) begin
      waw_q <= 1'b1;
    end
  end

  assign bus.lsu_ready = !full;
  assign bus.hz_rs1    = (pending[bus.rs1] != '0);
  assign bus.hz_rs2    = (pending[bus.rs2] != '0);
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.waw_err   = waw_q;
  assign bus.busy      = !empty || wb_we_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based model of the writeback rules.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;
  localparam int PMAX  = (1 << CNTW) - 1;

  logic clk;
  logic rst_n;
  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          pend [32];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_waw;

  // current stimulus, kept locally so the model never reads the DUT
  logic        c_av, c_lv, c_iv;
  logic [4:0]  c_ard, c_lrd, c_ird, c_r1, c_r2;
  logic [31:0] c_ad, c_ld;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    exp_waw  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("lsu_ready", bus.lsu_ready, q.size() < DEPTH);
    chk("hz_rs1",    bus.hz_rs1,    pend[c_r1] != 0);
    chk("hz_rs2",    bus.hz_rs2,    pend[c_r2] != 0);
    chk("wb_we",     bus.wb_we,     exp_we);
    chk("wb_rd",     bus.wb_rd,     exp_rd);
    chk("wb_data",   bus.wb_data,   exp_data);
    chk("waw_err",   bus.waw_err,   exp_waw);
    chk("busy",      bus.busy,      (q.size() != 0) || exp_we);
  endtask

  // Apply the writeback rules to the model for one clock edge.
  task automatic model_step();
    ent_t h;
    bit   accept;
    bit   popped;
    int   d;
    accept = c_lv && (q.size() < DEPTH);
    popped = 0;
    h.rd   = '0;
    h.data = '0;
    if (c_av && c_ard != 0) begin
      if (pend[c_ard] != 0) exp_waw = 1'b1;
      exp_we   = 1'b1;
      exp_rd   = c_ard;
      exp_data = c_ad;
    end else if (q.size() > 0) begin
      h        = q.pop_front();
      popped   = 1;
      exp_we   = 1'b1;
      exp_rd   = h.rd;
      exp_data = h.data;
    end else begin
      exp_we = 1'b0;
    end
    if (accept && c_lrd != 0) begin
      ent_t e;
      e.rd   = c_lrd;
      e.data = c_ld;
      q.push_back(e);
    end
    for (int r = 1; r < 32; r++) begin
      d = 0;
      if (c_iv && c_ird == r) d = d + 1;
      if (popped && h.rd == r) d = d - 1;
      if (d > 0 && pend[r] < PMAX) pend[r] = pend[r] + 1;
      else if (d < 0 && pend[r] > 0) pend[r] = pend[r] - 1;
    end
  endtask

  // One clock cycle: drive, check current outputs, advance model, clock.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    c_av = av; c_ard = ard; c_ad = ad;
    c_lv = lv; c_lrd = lrd; c_ld = ld;
    c_iv = iv; c_ird = ird; c_r1 = r1; c_r2 = r2;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
    bus.iss_valid = iv; bus.iss_rd = ird; bus.rs1 = r1; bus.rs2 = r2;
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] r1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  // Assert reset asynchronously and check outputs before any clock edge.
  task automatic apply_reset(input logic [4:0] r1);
    c_av = 0; c_lv = 0; c_iv = 0; c_r1 = r1; c_r2 = r1;
    bus.alu_valid = 0; bus.lsu_valid = 0; bus.iss_valid = 0;
    bus.rs1 = r1; bus.rs2 = r1;
    rst_n = 1'b0;
    #1;
    chk("rst_wb_we",     bus.wb_we,     1'b0);
    chk("rst_wb_rd",     bus.wb_rd,     5'd0);
    chk("rst_wb_data",   bus.wb_data,   32'd0);
    chk("rst_lsu_ready", bus.lsu_ready, 1'b1);
    chk("rst_hz_rs1",    bus.hz_rs1,    1'b0);
    chk("rst_hz_rs2",    bus.hz_rs2,    1'b0);
    chk("rst_busy",      bus.busy,      1'b0);
    chk("rst_waw",       bus.waw_err,   1'b0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset(5'd0);

    // ALU path: rd 3 written one edge later; rd 0 produces no write
    cycle(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_we", bus.wb_we, 1'b1);
    chk("alu_rd", bus.wb_rd, 5'd3);
    chk("alu_data", bus.wb_data, 32'hDEADBEEF);
    cycle(1, 5'd0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_x0_we", bus.wb_we, 1'b0);
    idle(0);

    // Load path: issue rd 7, push it, watch the hazard and the write
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    chk("ld_hz_set", bus.hz_rs1, 1'b1);
    cycle(0, 0, 0, 1, 5'd7, 32'h12345678, 0, 0, 5'd7, 0);
    idle(7);
    chk("ld_we", bus.wb_we, 1'b1);
    chk("ld_data", bus.wb_data, 32'h12345678);
    chk("ld_hz_clr", bus.hz_rs1, 1'b0);
    idle(7);

    // Contention: four pushes while ALU owns the port, then drain in order
    for (int i = 1; i <= 4; i++)
      cycle(1, 5'(10 + i), 32'hA0 + i, 1, 5'(i), 32'hB0 + i, 0, 0, 0, 0);
    chk("full_ready", bus.lsu_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      idle(0);
      chk("drain_we", bus.wb_we, 1'b1);
      chk("drain_rd", bus.wb_rd, 5'(i));
    end
    idle(0);

    // Simultaneous issue and pop on rd 9; push+pop at two entries
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0);
    cycle(1, 5'd20, 32'h1, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 0);
    cycle(1, 5'd21, 32'h2, 1, 5'd8, 32'h88, 0, 0, 5'd9, 0);
    cycle(0, 0, 0, 1, 5'd10, 32'hAA, 1, 5'd9, 5'd9, 0);
    idle(9);
    idle(9);
    idle(9);

    // WAW: outstanding load on rd 6 and an ALU write to rd 6
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd6, 0);
    cycle(1, 5'd6, 32'h66, 0, 0, 0, 0, 0, 5'd6, 0);
    chk("waw_set", bus.waw_err, 1'b1);
    cycle(0, 0, 0, 1, 5'd6, 32'h606, 0, 0, 5'd6, 0);
    idle(6);
    idle(6);
    chk("waw_sticky", bus.waw_err, 1'b1);

    // Mid-traffic reset: three buffered loads, pending[5] = 2
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 5'd11, 32'hC0 + i, 1, 5'd5, 32'hD0 + i, 0, 0, 5'd5, 0);
    chk("pre_rst_hz", bus.hz_rs1, 1'b1);
    chk("pre_rst_busy", bus.busy, 1'b1);
    apply_reset(5'd5);
    idle(5);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (n == 1000) apply_reset(5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 8; n++) idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
